// File: rtl/fpga_spi_slave_if.sv
// SPI slave bus: serial pins from the master plus the received-byte status
// that is handed to the rest of the FPGA design.
interface fpga_spi_slave_if;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport slave (
    input  sclk,
    input  mosi,
    input  ss,
    output miso,
    output rx_data,
    output rx_valid
  );

  modport master (
    output sclk,
    output mosi,
    output ss,
    input  miso,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/fpga_spi_slave.sv
// SPI mode-0 slave, 8-bit MSB-first frames, oversampled in the clk domain.
// Every received byte is echoed on MISO during the following frame.
module fpga_spi_slave #(
  parameter logic [7:0] TX_INIT     = 8'h9D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fpga_spi_slave_if.slave   spi
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic                   sclk_d_r;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   rise_s;
  logic                   fall_s;
  logic [7:0]             rx_byte_s;

  logic [2:0]             cnt_r;
  logic [7:0]             rx_shift_r;
  logic [7:0]             tx_shift_r;
  logic [7:0]             tx_next_r;
  logic                   reload_r;
  logic [7:0]             rx_data_r;
  logic                   rx_valid_r;

  // Input synchronizers; SS resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      ss_sync_r   <= '1;
      sclk_d_r    <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.mosi};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi.ss};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign ss_s      = ss_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_d_r;
  assign fall_s    = ~sclk_s & sclk_d_r;
  assign rx_byte_s = {rx_shift_r[6:0], mosi_s};

  // Frame engine: an SS high level overrides any coincident SCLK edge, which
  // also discards a partial byte and rearms tx_shift with the pending echo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= TX_INIT;
      tx_next_r  <= TX_INIT;
      reload_r   <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (ss_s) begin
        cnt_r      <= 3'd0;
        tx_shift_r <= tx_next_r;
        reload_r   <= 1'b0;
      end else if (rise_s) begin
        rx_shift_r <= rx_byte_s;
        cnt_r      <= cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          rx_data_r  <= rx_byte_s;
          rx_valid_r <= 1'b1;
          tx_next_r  <= rx_byte_s;
          reload_r   <= 1'b1;
        end else begin
          reload_r   <= reload_r;
        end
      end else if (fall_s) begin
        if (reload_r) begin
          tx_shift_r <= tx_next_r;
          reload_r   <= 1'b0;
        end else begin
          tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // MISO follows tx_shift directly so bit 7 is ready before the first rise.
  assign spi.miso     = ss_s ? 1'b0 : tx_shift_r[7];
  assign spi.rx_data  = rx_data_r;
  assign spi.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_fpga_spi_slave.sv
// Directed bench for fpga_spi_slave: a mode-0 master drives frames while a
// monitor checks every RX_VALID pulse against a queue of expected bytes.
module tb_fpga_spi_slave;
  localparam int HALF = 5;

  logic clk;
  logic rst_n;
  fpga_spi_slave_if spi_if ();

  fpga_spi_slave #(.TX_INIT(8'h9D), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         vcount = 0;
  logic [7:0] exp_q[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RX_VALID pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && spi_if.rx_valid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_valid_unexpected: got data %h expected no pulse", spi_if.rx_data);
      end else begin
        check8("rx_data_monitor", spi_if.rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    spi_if.ss = 1'b0;
  endtask

  task automatic ss_high();
    wait_clk(HALF);
    spi_if.ss = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    spi_if.mosi = b;
    wait_clk(HALF);
    m = spi_if.miso;
    spi_if.sclk = 1'b1;
    wait_clk(HALF);
    spi_if.sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic frame(input string name, input logic [7:0] tx, input logic [7:0] exp_rx);
    logic [7:0] rx;
    int         v0;
    exp_q.push_back(tx);
    v0 = vcount;
    ss_low();
    xfer_byte(tx, rx);
    ss_high();
    check8({name, "_miso"}, rx, exp_rx);
    check8({name, "_pulses"}, 8'(vcount - v0), 8'd1);
    check8({name, "_rx_data"}, spi_if.rx_data, tx);
  endtask

  initial begin
    logic [7:0] r1;
    logic [7:0] r2;
    logic [3:0] nib;
    logic       m;
    int         v0;

    rst_n       = 1'b0;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    spi_if.ss   = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    check8("reset_miso", {7'd0, spi_if.miso}, 8'd0);
    check8("reset_rx_data", spi_if.rx_data, 8'h00);
    check8("reset_rx_valid", {7'd0, spi_if.rx_valid}, 8'd0);

    frame("f1", 8'h00, 8'h9D);
    frame("f2", 8'h9D, 8'h00);
    frame("f3", 8'h00, 8'h9D);

    // Two bytes under one SS assertion.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    v0 = vcount;
    ss_low();
    xfer_byte(8'hA5, r1);
    xfer_byte(8'h3C, r2);
    ss_high();
    check8("stream_miso0", r1, 8'h00);
    check8("stream_miso1", r2, 8'hA5);
    check8("stream_pulses", 8'(vcount - v0), 8'd2);
    check8("stream_rx_data", spi_if.rx_data, 8'h3C);

    // Abort after four bits of 0xF0.
    v0 = vcount;
    ss_low();
    for (int i = 3; i >= 0; i--) begin
      xfer_bit(1'b1, m);
      nib[i] = m;
    end
    ss_high();
    check8("abort_miso_nibble", {4'd0, nib}, 8'h03);
    check8("abort_pulses", 8'(vcount - v0), 8'd0);
    check8("abort_rx_data", spi_if.rx_data, 8'h3C);
    check8("abort_idle_miso", {7'd0, spi_if.miso}, 8'd0);
    frame("after_abort", 8'h5A, 8'h3C);

    // Reset three bits into a frame while MISO is driving a 1.
    ss_low();
    for (int i = 0; i < 3; i++) begin
      xfer_bit(1'b1, m);
    end
    wait_clk(HALF);
    check8("pre_reset_miso", {7'd0, spi_if.miso}, 8'd1);
    rst_n = 1'b0;
    #1;
    check8("mid_reset_miso", {7'd0, spi_if.miso}, 8'd0);
    check8("mid_reset_rx_data", spi_if.rx_data, 8'h00);
    spi_if.ss = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);

    // SCLK activity with SS high must be ignored.
    v0 = vcount;
    for (int i = 0; i < 4; i++) begin
      spi_if.sclk = 1'b1;
      wait_clk(HALF);
      spi_if.sclk = 1'b0;
      wait_clk(HALF);
    end
    check8("idle_sclk_pulses", 8'(vcount - v0), 8'd0);
    check8("idle_sclk_miso", {7'd0, spi_if.miso}, 8'd0);
    check8("post_reset_rx_data", spi_if.rx_data, 8'h00);
    frame("post_reset", 8'h81, 8'h9D);

    check8("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpga_spi_slave.md
Name: fpga_spi_slave

Overview:
SPI slave, mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first. SCLK, MOSI and SS are sampled in the system CLK domain. Each received byte is echoed back to the master on MISO during the following frame. The received byte is also presented on a status output to the rest of the FPGA design.

Parameters:
TX_INIT, 8'h9D, byte transmitted in the first frame after reset.
SYNC_STAGES, 2, synchronizer depth for SCLK/MOSI/SS (minimum 2).

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
RST_N  input  1  asynchronous active-low reset.
SCLK  input  1  SPI serial clock from the master; idles low.
MOSI  input  1  master-out data.
SS  input  1  active-low slave select.
MISO  output  1  slave-out data.
RX_DATA  output  8  last complete received byte.
RX_VALID  output  1  one-CLK pulse when RX_DATA updates.

Behaviour:
- Reset (RST_N=0, asynchronous): RX_DATA=0, RX_VALID=0, MISO=0, bit counter=0, tx_shift=TX_INIT, tx_next=TX_INIT, synchronizers cleared (SS sync cleared to 1).
- Synchronization:
  - SCLK, MOSI and SS pass through SYNC_STAGES flip-flops.
  - Edges are detected by comparing the synchronized SCLK with its 1-cycle delayed copy.
  - Total input-to-action latency is SYNC_STAGES+1 CLK.
  - Requirement on the master: SCLK high and low phases each last at least SYNC_STAGES+2 CLK periods. At 50 MHz CLK, SCLK half-period ≥ 80 ns; the bench uses 100 ns.
- Idle (ss_s=1):
  - MISO=0.
  - Bit counter=0.
  - tx_shift continuously loaded with tx_next.
  - SCLK edges are ignored.
- Frame (ss_s=0):
  - MISO = tx_shift[7] combinationally, so the first bit is valid within SYNC_STAGES+1 CLK of SS falling, before the first SCLK rise.
  - SCLK rising edge: rx_shift = {rx_shift[6:0], mos_s}; counter increments.
  - When the counter reaches 8:
    - RX_DATA <= assembled byte.
    - RX_VALID=1 for exactly one CLK.
    - tx_next <= assembled byte.
    - Counter wraps to 0.
    - reload flag set.
  - SCLK falling edge:
    - If reload flag is set: tx_shift <= tx_next and the flag is cleared.
    - Otherwise: tx_shift shifts left by 1, filling with 0.
  - MISO therefore changes only after SCLK falls; the master samples it on the next rise.
- Back-to-back bytes without SS deassertion: continuous streaming. Byte n+1 transmitted equals byte n received.
- SS deasserted mid-frame (counter 1..7):
  - Partial byte discarded; no RX_VALID; RX_DATA and tx_next unchanged.
  - Counter=0; MISO=0.
  - tx_shift is reloaded from tx_next, so the next frame retransmits the same byte.
- SS deasserted exactly after 8 bits: normal end of frame; the received byte is already captured.
- SCLK edges while SS high: no effect on any state.
- Reset mid-frame: all state returns to reset values immediately; the next frame transmits TX_INIT.
- Simultaneous SS rise and SCLK edge in the same synchronized cycle: SS takes priority and the edge is ignored.

Test Plan:
- Reset then idle: RST_N low 3 CLK, release, SS=1 -> MISO=0, RX_DATA=0x00, RX_VALID=0.
- Frame 1: master sends 0x00 MSB first (mode 0, SCLK half-period 5 CLK) -> master receives 0x9D; RX_DATA=0x00; RX_VALID pulses once after 8th rise.
- Frame 2: master sends 0x9D -> master receives 0x00; RX_DATA=0x9D. Frame 3: master sends 0x00 -> master receives 0x9D.
- Streaming: SS held low for 16 bits, master sends 0xA5 then 0x3C -> master receives previous rx byte then 0xA5; RX_VALID pulses twice; RX_DATA ends 0x3C.
- Abort: SS raised after 4 bits of 0xF0 -> no RX_VALID, RX_DATA unchanged; next full frame returns the same byte as the aborted frame.
- Reset mid-frame after 3 bits -> MISO=0 immediately; next frame master receives 0x9D; RX_DATA=0 until that frame completes.
